// File: rtl/stack_arbiter_pkg.sv
// Shared types and default sizing for the evaluation-stack arbiter.
// Build option STACK_ARB_RR_EN selects round-robin arbitration in stack_grant_sel.
package bali_stack_pkg;

    localparam int STACK_WIDTH   = 32;
    localparam int STACK_DEPTH   = 256;
    localparam int STACK_TIMEOUT = 15;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {REQ_C, REQ_D} req_id_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side bundle of the stack arbiter: control port C, debug port D and
// the shared pop result. The requesters are the master, the arbiter the slave.
interface stack_arbiter_if #(parameter int WIDTH = 32);

    logic             c_req;
    logic             c_push;
    logic [WIDTH-1:0] c_wdata;
    logic             c_done;
    logic             c_err;

    logic             d_req;
    logic             d_push;
    logic [WIDTH-1:0] d_wdata;
    logic             d_done;
    logic             d_err;

    logic [WIDTH-1:0] rdata;

    modport master (
        output c_req, c_push, c_wdata, d_req, d_push, d_wdata,
        input  c_done, c_err, d_done, d_err, rdata
    );

    modport slave (
        input  c_req, c_push, c_wdata, d_req, d_push, d_wdata,
        output c_done, c_err, d_done, d_err, rdata
    );

endinterface

// File: rtl/stack_grant_sel.sv
// Combinational winner selection between ports C and D.
// STACK_ARB_RR_EN defined: round-robin on contention; undefined: C has fixed priority.
module stack_grant_sel
    import bali_stack_pkg::*;
(
    input  logic    c_req,
    input  logic    d_req,
`ifdef STACK_ARB_RR_EN
    input  req_id_t last_grant,
`endif
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = c_req | d_req;
        grant_id    = REQ_C;
`ifdef STACK_ARB_RR_EN
        if (c_req && d_req)
            grant_id = (last_grant == REQ_C) ? REQ_D : REQ_C;
        else if (d_req)
            grant_id = REQ_D;
`else
        if (!c_req && d_req)
            grant_id = REQ_D;
`endif
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares stack32 between the control (C) and debug (D) ports, guarding depth and
// bounding each access with a timeout. STACK_ARB_RR_EN selects round-robin arbitration.
module stack_arbiter
    import bali_stack_pkg::*;
#(
    parameter int WIDTH   = STACK_WIDTH,
    parameter int DEPTH   = STACK_DEPTH,
    parameter int TIMEOUT = STACK_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    stack_arbiter_if.slave             bus,
    output logic                       stk_trigger,
    output logic                       stk_push,
    output logic [WIDTH-1:0]           stk_write,
    input  logic [WIDTH-1:0]           stk_read,
    input  logic                       stk_done,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       busy
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    req_id_t          owner;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] rdata_q;
    logic             c_done_q, c_err_q, d_done_q, d_err_q;

    logic             grant_valid;
    req_id_t          grant_id;
    logic             req_push;
    logic [WIDTH-1:0] req_wdata;
    logic             reject;

`ifdef STACK_ARB_RR_EN
    req_id_t last_grant;

    stack_grant_sel u_grant_sel (
        .c_req       (bus.c_req),
        .d_req       (bus.d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );
`else
    stack_grant_sel u_grant_sel (
        .c_req       (bus.c_req),
        .d_req       (bus.d_req),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );
`endif

    assign req_push  = (grant_id == REQ_C) ? bus.c_push  : bus.d_push;
    assign req_wdata = (grant_id == REQ_C) ? bus.c_wdata : bus.d_wdata;
    // Overflow/underflow are refused here so the stack never sees an illegal access.
    assign reject    = req_push ? (depth == DW'(DEPTH)) : (depth == '0);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
        if (rst) begin
            state       <= IDLE;
            owner       <= REQ_C;
            timer       <= '0;
            depth       <= '0;
            rdata_q     <= '0;
            c_done_q    <= 1'b0;
            c_err_q     <= 1'b0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            stk_trigger <= 1'b0;
            stk_push    <= 1'b0;
            stk_write   <= '0;
`ifdef STACK_ARB_RR_EN
            last_grant  <= REQ_D;
`endif
        end else begin
            c_done_q    <= 1'b0;
            c_err_q     <= 1'b0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            stk_trigger <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    owner <= grant_id;
`ifdef STACK_ARB_RR_EN
                    last_grant <= grant_id;
`endif
                    if (reject) begin
                        state    <= RESP;
                        c_done_q <= (grant_id == REQ_C);
                        c_err_q  <= (grant_id == REQ_C);
                        d_done_q <= (grant_id == REQ_D);
                        d_err_q  <= (grant_id == REQ_D);
                    end else begin
                        state       <= ISSUE;
                        stk_trigger <= 1'b1;
                        stk_push    <= req_push;
                        stk_write   <= req_wdata;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (stk_done) begin
                    state    <= RESP;
                    c_done_q <= (owner == REQ_C);
                    d_done_q <= (owner == REQ_D);
                    if (stk_push) begin
                        depth <= depth + DW'(1);
                    end else begin
                        depth   <= depth - DW'(1);
                        rdata_q <= stk_read;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state    <= RESP;
                    c_done_q <= (owner == REQ_C);
                    c_err_q  <= (owner == REQ_C);
                    d_done_q <= (owner == REQ_D);
                    d_err_q  <= (owner == REQ_D);
                end else begin
                    timer <= timer + TW'(1);
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.c_done = c_done_q;
    assign bus.c_err  = c_err_q;
    assign bus.d_done = d_done_q;
    assign bus.d_err  = d_err_q;
    assign bus.rdata  = rdata_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter with a behavioural stack32 and a queue-based
// reference model; builds with or without STACK_ARB_RR_EN.
module tb_stack_arbiter;
    import bali_stack_pkg::*;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 15;
    localparam int DW = $clog2(D + 1);
`ifdef STACK_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stk_trigger, stk_push, stk_done, busy;
    logic [W-1:0]  stk_write, stk_read;
    logic [DW-1:0] depth;

    always #5 clk = ~clk;

    stack_arbiter_if #(.WIDTH(W)) bus ();

    stack_arbiter #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .stk_trigger (stk_trigger),
        .stk_push    (stk_push),
        .stk_write   (stk_write),
        .stk_read    (stk_read),
        .stk_done    (stk_done),
        .depth       (depth),
        .busy        (busy)
    );

    // Behavioural stack32: answers a trigger after 1+extra_lat cycles unless silent.
    logic [W-1:0] mem [$];
    bit           silent      = 1'b0;
    bit           inject_done = 1'b0;
    int           extra_lat   = 0;
    logic         done_q      = 1'b0;
    logic         pend        = 1'b0;
    int           pend_cnt    = 0;
    logic         pend_push   = 1'b0;
    logic [W-1:0] pend_data   = '0;

    assign stk_done = done_q | inject_done;

    function automatic logic [W-1:0] stack_pop();
        if (mem.size() == 0) return 32'hBAD0_BAD0;
        return mem.pop_back();
    endfunction

    always @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            mem.delete();
            pend     <= 1'b0;
            stk_read <= '0;
        end else if (stk_trigger && !silent && extra_lat == 0) begin
            if (stk_push) mem.push_back(stk_write);
            else stk_read <= stack_pop();
            done_q <= 1'b1;
        end else if (stk_trigger && !silent) begin
            pend      <= 1'b1;
            pend_cnt  <= extra_lat - 1;
            pend_push <= stk_push;
            pend_data <= stk_write;
        end else if (pend) begin
            if (pend_cnt == 0) begin
                pend <= 1'b0;
                if (pend_push) mem.push_back(pend_data);
                else stk_read <= stack_pop();
                done_q <= 1'b1;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Event monitors
    int           trig_cnt   = 0;
    int           c_done_cnt = 0;
    int           d_done_cnt = 0;
    logic         trig_push  = 1'b0;
    logic [W-1:0] trig_write = '0;

    always @(posedge clk) begin
        if (stk_trigger) begin
            trig_cnt   <= trig_cnt + 1;
            trig_push  <= stk_push;
            trig_write <= stk_write;
        end
        if (bus.c_done) c_done_cnt <= c_done_cnt + 1;
        if (bus.d_done) d_done_cnt <= d_done_cnt + 1;
    end

    // Reference model: stack contents as a queue, plus the last popped value.
    logic [W-1:0] model [$];
    logic [W-1:0] model_rdata = '0;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        silent = 1'b0;
        inject_done = 1'b0;
        extra_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        model_rdata = '0;
    endtask

    task automatic single_op(input bit is_c, input bit push, input logic [W-1:0] data,
                             input bit no_resp, input int extra);
        int exp_lat, cyc, trig0, c0, d0;
        bit fast, exp_err, seen;
        fast    = push ? (model.size() == D) : (model.size() == 0);
        exp_err = fast || no_resp;
        exp_lat = fast ? 1 : (no_resp ? TO + 2 : extra + 3);
        if (!exp_err) begin
            if (push) model.push_back(data);
            else model_rdata = model.pop_back();
        end
        silent    = no_resp;
        extra_lat = extra;
        trig0 = trig_cnt;
        c0    = c_done_cnt;
        d0    = d_done_cnt;
        if (is_c) begin
            bus.c_req = 1'b1; bus.c_push = push; bus.c_wdata = data;
        end else begin
            bus.d_req = 1'b1; bus.d_push = push; bus.d_wdata = data;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
            seen = is_c ? bus.c_done : bus.d_done;
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        check("done_seen", seen, 1);
        check("latency", cyc, exp_lat);
        check("err", is_c ? bus.c_err : bus.d_err, exp_err);
        check("other_done", is_c ? bus.d_done : bus.c_done, 0);
        check("depth", depth, model.size());
        check("rdata", bus.rdata, model_rdata);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("trig_count", trig_cnt - trig0, fast ? 0 : 1);
        check("own_done_cnt", is_c ? c_done_cnt - c0 : d_done_cnt - d0, 1);
        check("other_done_cnt", is_c ? d_done_cnt - d0 : c_done_cnt - c0, 0);
        if (!fast) begin
            check("stk_push", trig_push, push);
            check("stk_write", trig_write, data);
        end
        silent = 1'b0;
    endtask

    initial begin
        int c0, d0, cyc, grants;
        bit last_c, c_live, raise_c, raise_d, got_c, exp_c, is_push, fast;
        logic [W-1:0] cdata;

        bus.c_req = 1'b0; bus.c_push = 1'b0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_push = 1'b0; bus.d_wdata = '0;
        do_reset();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_depth", depth, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_trigger", stk_trigger, 0);
        check("rst_stk_push", stk_push, 0);
        check("rst_stk_write", stk_write, 0);
        check("rst_dones", {bus.c_done, bus.c_err, bus.d_done, bus.d_err}, 0);

        // Underflow on D, then push/pop round trip on C
        single_op(1'b0, 1'b0, 32'h0, 1'b0, 0);
        single_op(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        single_op(1'b1, 1'b0, 32'h0000_0000, 1'b0, 0);

        // Fill to capacity with varied stack latency, then overflow
        for (int i = 0; i < D; i++) single_op(1'b1, 1'b1, $urandom, 1'b0, i);
        single_op(1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 0);

        // Timeout on a pop from a full stack
        single_op(1'b0, 1'b0, 32'h0, 1'b1, 0);

        // Reset during WAIT of a push, then a late stk_done
        do_reset();
        silent = 1'b1;
        bus.c_req = 1'b1; bus.c_push = 1'b1; bus.c_wdata = 32'hCAFE_0001;
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1);
        c0 = c_done_cnt;
        d0 = d_done_cnt;
        rst = 1'b1;
        bus.c_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_depth", depth, 0);
        check("mid_rst_done", bus.c_done, 0);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        silent = 1'b0;
        @(negedge clk);
        check("late_done_busy", busy, 0);
        check("late_done_depth", depth, 0);
        check("late_done_pulses", (c_done_cnt - c0) + (d_done_cnt - d0), 0);
        single_op(1'b1, 1'b1, 32'h1234_5678, 1'b0, 0);

        // Contention: C pushes, D pops, both re-raise immediately; C drops after four grants
        do_reset();
        last_c  = 1'b0;
        raise_c = 1'b0;
        raise_d = 1'b0;
        grants  = 0;
        cyc     = 0;
        cdata   = $urandom;
        bus.c_req = 1'b1; bus.c_push = 1'b1; bus.c_wdata = cdata;
        bus.d_req = 1'b1; bus.d_push = 1'b0; bus.d_wdata = '0;
        while (grants < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (raise_c) begin
                cdata = $urandom;
                bus.c_req = 1'b1; bus.c_wdata = cdata;
                raise_c = 1'b0;
            end
            if (raise_d) begin
                bus.d_req = 1'b1;
                raise_d = 1'b0;
            end
            if (bus.c_done || bus.d_done) begin
                c_live = (grants < 4);
                exp_c  = c_live && (RR ? !last_c : 1'b1);
                got_c  = bus.c_done;
                check("cont_winner", got_c, exp_c);
                check("cont_single_done", bus.c_done & bus.d_done, 0);
                is_push = exp_c;
                fast = is_push ? (model.size() == D) : (model.size() == 0);
                if (!fast) begin
                    if (is_push) model.push_back(cdata);
                    else model_rdata = model.pop_back();
                end
                check("cont_err", exp_c ? bus.c_err : bus.d_err, fast);
                check("cont_depth", depth, model.size());
                check("cont_rdata", bus.rdata, model_rdata);
                last_c = exp_c;
                grants++;
                if (got_c) begin
                    bus.c_req = 1'b0;
                    raise_c = (grants < 4);
                end else begin
                    bus.d_req = 1'b0;
                    raise_d = 1'b1;
                end
                if (grants == 4) begin
                    bus.c_req = 1'b0;
                    raise_c = 1'b0;
                end
            end
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        check("cont_grants", grants, 5);
        @(negedge clk);
        @(negedge clk);

        // Randomized single-requester traffic
        for (int i = 0; i < 40; i++) begin
            single_op($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                      ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
